// File: rtl/histogram_loader_if.sv
// histogram_loader_if: SD read channel plus histogram RAM write port, grouped for histogram_loader.
interface histogram_loader_if;
  logic        sd_ready;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic        we;

  // Loader side: issues reads, consumes bytes, writes RAM words.
  modport master (
    input  sd_ready, sd_dout, sd_byte_available,
    output sd_rd, sd_address, waddr, wdata, we
  );

  // SD controller / RAM side.
  modport slave (
    output sd_ready, sd_dout, sd_byte_available,
    input  sd_rd, sd_address, waddr, wdata, we
  );
endinterface

// File: rtl/histogram_loader.sv
// histogram_loader: restores a 1024 x 16-bit histogram from four 512-byte SD sectors
// into the histogram RAM write port. Bins are stored big-endian (high byte first).
// Optional: define LOADER_CHECKSUM_EN to add a 16-bit running sum of written words.
module histogram_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int unsigned SLOT_BITS   = 3,
  parameter logic [31:0] SLOT_STRIDE = 32'd2048
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SLOT_BITS-1:0] slot,
  histogram_loader_if.master   bus,
  output logic                 loading,
  output logic                 done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, READ, NEXT, FIN} state_t;

  state_t               state;
  logic [SLOT_BITS-1:0] slot_q;
  logic [1:0]           sector;
  logic [8:0]           byte_cnt;
  logic [9:0]           word_cnt;
  logic [7:0]           hi_byte;
  logic                 bav_q;
  logic                 byte_edge_c;
  logic [31:0]          addr_c;

  // One byte per rising edge of the byte-valid level.
  assign byte_edge_c = bus.sd_byte_available & ~bav_q;

  // Sector byte address for the latched slot and current sector.
  assign addr_c = BASE_ADDR + 32'(slot_q) * SLOT_STRIDE + {21'd0, sector, 9'd0};

  // Load sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      slot_q         <= '0;
      sector         <= 2'd0;
      byte_cnt       <= 9'd0;
      word_cnt       <= 10'd0;
      hi_byte        <= 8'd0;
      bav_q          <= 1'b0;
      bus.sd_rd      <= 1'b0;
      bus.sd_address <= 32'd0;
      bus.waddr      <= 10'd0;
      bus.wdata      <= 16'd0;
      bus.we         <= 1'b0;
      loading        <= 1'b0;
      done           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum       <= 16'd0;
`endif
    end else begin
      bav_q  <= bus.sd_byte_available;
      bus.we <= 1'b0;
      done   <= 1'b0;
      // Word address advances the cycle after each write.
      if (bus.we) begin
        word_cnt <= word_cnt + 10'd1;
`ifdef LOADER_CHECKSUM_EN
        checksum <= checksum + bus.wdata;
`endif
      end
      case (state)
        IDLE: begin
          if (start) begin
            slot_q   <= slot;
            sector   <= 2'd0;
            byte_cnt <= 9'd0;
            word_cnt <= 10'd0;
            loading  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            checksum <= 16'd0;
`endif
            state    <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          bus.sd_address <= addr_c;
          if (bus.sd_ready) begin
            bus.sd_rd <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Hold the request until the controller acknowledges by dropping ready.
          if (!bus.sd_ready) begin
            bus.sd_rd <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          if (byte_edge_c) begin
            if (!byte_cnt[0]) begin
              hi_byte <= bus.sd_dout;
            end else begin
              bus.wdata <= {hi_byte, bus.sd_dout};
              bus.waddr <= word_cnt;
              bus.we    <= 1'b1;
            end
            byte_cnt <= byte_cnt + 9'd1;
            if (byte_cnt == 9'd511) state <= NEXT;
          end
        end
        NEXT: begin
          // done lands in the cycle right after the final write.
          if (sector == 2'd3) begin
            done    <= 1'b1;
            loading <= 1'b0;
            state   <= FIN;
          end else begin
            sector   <= sector + 2'd1;
            byte_cnt <= 9'd0;
            state    <= WAIT_RDY;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_loader.sv
// tb_histogram_loader: scoreboard bench with a behavioural SD controller model.
module tb_histogram_loader;
  localparam logic [31:0] BASE   = 32'h10000;
  localparam logic [31:0] STRIDE = 32'd2048;
  localparam int unsigned SB     = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [SB-1:0] slot = '0;
  logic          loading;
  logic          done;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  histogram_loader_if bus();

  histogram_loader #(.BASE_ADDR(BASE), .SLOT_BITS(SB), .SLOT_STRIDE(STRIDE)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .slot    (slot),
    .bus     (bus),
    .loading (loading),
    .done    (done)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard and model controls
  logic [25:0] exp_q[$];
  int          exp_slot = 0;
  int          m_mode   = 0;
  int          m_hold   = 1;
  bit          m_early  = 1'b0;
  int          m_sec    = 0;
  logic [15:0] exp_sum  = 16'd0;
  logic [31:0] first_addr, last_addr;

  // Monitor state
  int          we_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic        prev_we = 1'b0, prev_rd = 1'b0;
  logic [9:0]  prev_waddr = 10'd0, last_waddr = 10'd0;
  logic [15:0] w0 = 16'hxxxx, w128 = 16'hxxxx;

  // SD controller model: ready drops on a read, 512 bytes follow, ready returns.
  initial begin : sd_model
    int   phase, cnt, i;
    logic [7:0] b, hi;
    logic [15:0] word;
    phase = 0; cnt = 0; i = 0; hi = 8'd0;
    bus.sd_ready = 1'b1;
    bus.sd_dout = 8'd0;
    bus.sd_byte_available = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        phase = 0; i = 0; cnt = 0;
        bus.sd_ready = 1'b1;
        bus.sd_byte_available = 1'b0;
      end else begin
        case (phase)
          0: if (bus.sd_rd) begin
            check("sd_address", bus.sd_address, BASE + 32'(exp_slot) * STRIDE + 32'(m_sec) * 32'd512);
            if (m_sec == 0) first_addr = bus.sd_address;
            last_addr = bus.sd_address;
            bus.sd_ready = 1'b0;
            phase = 1; cnt = 2; i = 0;
          end
          1: if (cnt > 0) cnt--;
            else begin
              case (m_mode)
                0:       b = 8'(i);
                1:       b = 8'hFF;
                default: b = 8'($urandom_range(0, 255));
              endcase
              bus.sd_dout = b;
              bus.sd_byte_available = 1'b1;
              if (i % 2 == 1) begin
                word = {hi, b};
                exp_q.push_back({10'(m_sec * 256 + i / 2), word});
                exp_sum = exp_sum + word;
              end else begin
                hi = b;
              end
              cnt = m_hold - 1;
              phase = 2;
            end
          default: if (cnt > 0) cnt--;
            else begin
              bus.sd_byte_available = 1'b0;
              i++;
              if (m_early && i == 256) bus.sd_ready = 1'b1;
              if (i == 512) begin
                bus.sd_ready = 1'b1;
                m_sec++;
                phase = 0;
              end else begin
                phase = 1; cnt = 0;
              end
            end
        endcase
      end
    end
  end

  // Output monitor: pops expected words, counts reads, checks done timing.
  initial begin : monitor
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_we = 1'b0; prev_rd = 1'b0; prev_waddr = 10'd0;
      end else begin
        if (bus.we) begin
          we_cnt++;
          if (exp_q.size() == 0) check("unexpected_we", {bus.waddr, bus.wdata}, 32'hFFFFFFFF);
          else begin
            e = exp_q.pop_front();
            check("word", {6'd0, bus.waddr, bus.wdata}, {6'd0, e});
          end
          if (bus.waddr == 10'd0)   w0   = bus.wdata;
          if (bus.waddr == 10'd128) w128 = bus.wdata;
          last_waddr = bus.waddr;
        end
        if (bus.sd_rd && !prev_rd) rd_cnt++;
        if (done) begin
          done_cnt++;
          check("done_after_last_we", {prev_we, prev_waddr}, {1'b1, 10'd1023});
          check("loading_low_at_done", loading, 1'b0);
        end
        prev_we = bus.we; prev_waddr = bus.waddr; prev_rd = bus.sd_rd;
      end
    end
  end

  task automatic start_load(input int s, input int mode, input int hold, input bit early);
    @(negedge clk);
    exp_slot = s; m_mode = mode; m_hold = hold; m_early = early; m_sec = 0;
    exp_sum = 16'd0; we_cnt = 0; rd_cnt = 0; done_cnt = 0;
    exp_q.delete();
    start = 1'b1; slot = SB'(s);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("loading_after_start", loading, 1'b1);
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (we_cnt < n && t < 30000) begin @(posedge clk); t++; end
    check("wait_words_timeout", 32'(we_cnt >= n), 32'd1);
  endtask

  task automatic finish_load(input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 30000) begin @(posedge clk); t++; end
    check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    @(negedge clk);
    check({tag, "_we_count"}, 32'(we_cnt), 32'd1024);
    check({tag, "_rd_count"}, 32'(rd_cnt), 32'd4);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_loading_idle"}, loading, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, exp_sum);
`endif
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("rst_sd_rd", bus.sd_rd, 1'b0);
    check("rst_sd_address", bus.sd_address, 32'd0);
    check("rst_waddr_wdata", {bus.waddr, bus.wdata}, 26'd0);
    check("rst_we_loading_done", {bus.we, loading, done}, 3'b000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp pattern, slot 0: word n = {2n, 2n+1} low bytes.
    start_load(0, 0, 1, 1'b0);
    finish_load("ramp");
    check("ramp_word0", w0, 16'h0001);
    check("ramp_word128", w128, 16'h0001);

    // Slot 2 address sequence.
    start_load(2, 0, 1, 1'b0);
    finish_load("slot2");
    check("slot2_first_addr", first_addr, 32'h11000);
    check("slot2_last_addr", last_addr, 32'h11600);

    // Byte-valid held 4 cycles, random data, ready rising early during READ.
    start_load(4, 2, 4, 1'b1);
    finish_load("hold4");

    // Second start mid-load must not re-latch the slot.
    start_load(1, 0, 1, 1'b0);
    wait_words(100);
    @(negedge clk); start = 1'b1; slot = SB'(5);
    @(negedge clk); start = 1'b0;
    check("loading_after_ignored_start", loading, 1'b1);
    finish_load("midstart");
    check("midstart_last_addr", last_addr, BASE + STRIDE + 32'd1536);

    // Reset in the middle of a load.
    start_load(3, 0, 1, 1'b0);
    wait_words(301);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_sd_rd_addr", {31'd0, bus.sd_rd} | bus.sd_address, 32'd0);
    check("midrst_waddr_wdata", {bus.waddr, bus.wdata}, 26'd0);
    check("midrst_we_loading_done", {bus.we, loading, done}, 3'b000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("midrst_stays_idle", {bus.sd_rd, loading}, 2'b00);
    w0 = 16'hxxxx;
    start_load(0, 0, 1, 1'b0);
    finish_load("reload");
    check("reload_word0", w0, 16'h0001);

    // All-ones data; checksum when the option is built in.
    start_load(6, 1, 1, 1'b0);
    finish_load("ones");
    check("ones_last_waddr", last_waddr, 10'd1023);
`ifdef LOADER_CHECKSUM_EN
    check("ones_checksum", checksum, 16'hFC00);
    repeat (10) @(negedge clk);
    check("ones_checksum_stable", checksum, 16'hFC00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/histogram_loader.md
Name: histogram_loader

Overview:
- Restores a saved histogram from the SD card into the histogram RAM; the read-side counterpart of histogram_saver.
- On start, it issues four 512-byte sector reads to sd_controller (2048 bytes = 1024 x 16-bit bins).
- It reassembles byte pairs into words and writes them to the RAM write port at addresses 0..1023.
- It sits between sd_controller (rd/dout/byte_available) and the histogram RAM port B.

Parameters:
- BASE_ADDR, 32'd0: SD byte address of slot 0; must be a multiple of 512.
- SLOT_BITS, 3: width of slot select.
- SLOT_STRIDE, 32'd2048: bytes per slot; must be a multiple of 512.

Ports:
- clk  in  1  system clock (25 MHz, same as sd_controller).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored while loading=1.
- slot  in  SLOT_BITS  slot index; latched on an accepted start.
- sd_ready  in  1  sd_controller ready.
- sd_rd  out  1  read request to sd_controller.
- sd_address  out  32  sector byte address = BASE_ADDR + slot*SLOT_STRIDE + sector*512.
- sd_dout  in  8  read byte from sd_controller.
- sd_byte_available  in  1  byte-valid level from sd_controller; may stay high for several cycles.
- waddr  out  10  histogram RAM write address.
- wdata  out  16  histogram RAM write data.
- we  out  1  histogram RAM write enable, one cycle per word.
- loading  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been written.

Behaviour:
- Reset values: sd_rd=0, sd_address=0, waddr=0, wdata=0, we=0, loading=0, done=0. FSM goes to IDLE; all counters and the byte latch clear.
- Reset mid-load: the load is abandoned immediately; nothing resumes after reset is released.
- States: IDLE, WAIT_RDY, ISSUE, READ, NEXT, FIN.
- IDLE:
  - start=1 latches slot, clears sector counter (2b), byte counter (9b) and word address, sets loading=1, goes to WAIT_RDY.
  - start while not IDLE is ignored.
- WAIT_RDY: sd_address is driven for the current sector. When sd_ready=1, go to ISSUE.
- ISSUE: sd_rd=1 and held until sd_ready samples 0, then sd_rd=0 and go to READ. sd_address stays stable throughout ISSUE and READ.
- READ:
  - Rising edge of sd_byte_available (registered previous value = 0, current = 1) accepts sd_dout as one byte. Exactly one byte is accepted per rising edge.
  - Even byte index: latch as high byte.
  - Odd byte index: wdata={high,sd_dout}, waddr=word counter, we=1 for exactly one cycle. Word counter increments on the cycle after we.
  - Byte order is big-endian per bin: high byte first, matching histogram_saver.
  - After byte 511 is accepted, go to NEXT.
- NEXT:
  - sector==3: go to FIN.
  - Otherwise: sector increments, byte counter clears, go to WAIT_RDY.
- FIN: done=1 for one cycle, loading=0, return to IDLE. done is asserted in the cycle after the final we.
- Word counter spans 0..1023 across all sectors: sector s writes words s*256..s*256+255. It never wraps within a load.
- Latency: each word is written 1 cycle after its odd-byte edge is sampled.
- Simultaneous start and reset: reset wins.
- A byte_available edge outside READ is ignored.
- sd_ready rising during READ is ignored until 512 bytes have been accepted.
- Address arithmetic is 32-bit unsigned and overflow wraps silently; configurations that overflow are not permitted.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [15:0].
  - checksum is the modulo-2^16 sum of all 1024 written wdata values.
  - It clears on an accepted start and updates on each we.
  - It is valid and stable from done until the next accepted start.
  - It resets to 0.
- When undefined: the port and adder are absent, and all other behaviour is identical.

Test Plan:
- SD model serves 2048 bytes with byte k = k[7:0], ready toggling per sector; start with slot=0 -> 1024 we pulses. Word n = {(2n)&FF, (2n+1)&FF}, e.g. waddr 0 = 16'h0001 and waddr 128 = 16'h0001 (wraps). done one cycle after waddr 1023.
- slot=2, BASE_ADDR=32'h10000 -> sd_address sequence 32'h11000, 32'h11200, 32'h11400, 32'h11600; exactly 4 sd_rd assertions.
- sd_byte_available held high 4 cycles per byte -> still exactly 512 bytes per sector and 256 we pulses per sector.
- start pulsed again mid-sector -> ignored; the load completes unchanged with slot not re-latched.
- reset asserted at word 300 -> all outputs 0 immediately. A fresh start reloads from sector 0, waddr 0.
- LOADER_CHECKSUM_EN defined, all bytes 8'hFF -> checksum = 16'hFC00 (1024 x 16'hFFFF mod 2^16); stable after done.
